arbiter_weighted_rr: RTL and testbench
======================================

// Module: arbiter_weighted_rr
// PURPOSE
// Weighted round-robin arbiter sharing one transfer resource between N requesters.
// The owner holds the grant for up to wgt+1 accepted transfers, then the grant rotates.
// A per-grant transfer counter wraps on a programmable maximum, with a last pulse.
// Sits between requester ports and a shared datapath; resource side signals each accepted transfer via ack.
// PARAMETERS
// N              4  number of requesters (>=2)
// WIDTH          8  width of per-requester weight and transfer counter
// IMPLEMENTATION 0  selector: 0 - masked dual priority encoder, 1 - rotate/encode/unrotate; other -> $fatal
// PORTS
// clk  input   1          clock
// rst  input   1          reset, asynchronous, active-high
// req  input   N          request per requester, level; held while data pending
// wgt  input   N*WIDTH    packed [N-1:0][WIDTH-1:0]; wgt[i]+1 = transfers per grant for requester i
// ack  input   1          resource accepted one transfer from current owner this cycle
// gnt  output  N          one-hot grant, registered; all-zero when idle
// cnt  output  WIDTH      accepted transfers in current grant, 0..wgt_l
// pls  output  1          last-transfer pulse: final transfer of current grant accepted
// BEHAVIOUR
// - Reset (async): gnt=0, cnt=0, state IDLE, round-robin pointer ptr=0; pls=0 (follows from gnt=0).
// - States: IDLE (gnt=0), BUSY (gnt one-hot). Registered: gnt, cnt, ptr, wgt_l, state.
// - Arbitration: first set req bit searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (mod N).
// - IDLE: if |req -> gnt<=selected, wgt_l<=wgt[selected], cnt<=0, state BUSY; grant visible 1 cycle after req.
// - BUSY, acc = ack & |(req & gnt): cnt<=cnt+1 on acc; ack with owner not requesting ignored.
// - pls = acc & (cnt == wgt_l), combinational; no other output is combinational.
// - Release rel = pls | ~|(req & gnt). On rel in same cycle:
//   ptr<=owner+1 mod N; cnt<=0; arbitrate req from owner+1 (owner eligible last);
//   winner found -> gnt<=winner, wgt_l<=wgt[winner], stay BUSY (zero-bubble handover);
//   none -> gnt<=0, state IDLE.
// - Sole requester still requesting after pls is re-granted, cnt restarts at 0, gnt unchanged.
// - wgt sampled only at grant start; changes mid-grant take effect at next grant to that requester.
// - wgt[i]=0: one transfer per grant; wgt[i]=2^WIDTH-1: 2^WIDTH transfers, cnt never overflows.
// - ack while IDLE: ignored, cnt stays 0, pls=0.
// - Owner drops req mid-grant: released without pls, cnt discarded.
// - Reset mid-grant: outputs cleared immediately; restart from ptr=0.
// - IMPLEMENTATION 0 and 1 cycle-identical at all outputs.
// TESTING (N=4, WIDTH=8; every scenario run for IMPLEMENTATION 0 and 1)
// 1 assert rst, req=1111, ack=1 -> gnt=0000, cnt=0, pls=0 while rst high
// 2 req=0010, wgt[1]=2, ack=1 each cycle -> gnt=0010 cycle after req; cnt 0,1,2; pls with 3rd ack; gnt stays 0010, cnt back 0
// 3 req=1111, all wgt=0, ack=1 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, pls every cycle, no idle gap
// 4 req=0101, wgt[0]=5, drop req[0] after 1 ack -> next cycle gnt=0100, cnt=0, pls never asserted for owner 0
// 5 wgt[1]=1 at grant, change to 7 mid-grant -> grant ends after 2 acks; next grant to 1 lasts 8; ack while idle -> cnt=0, pls=0
// 6 rst pulse mid-grant with gnt=0100, cnt=3, then req=1001 -> gnt=0000 during rst; after release gnt=0001

Source files
------------

// File: rtl/arbiter_weighted_rr.sv
// Weighted round-robin arbiter: the owner keeps the grant for up to wgt+1 accepted
// transfers, then the grant rotates to the next requester with no idle cycle in between.
module arbiter_weighted_rr #(
    parameter int N              = 4,
    parameter int WIDTH          = 8,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wgt,
    input  logic                 ack,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     cnt,
    output logic                 pls
);
    localparam int PW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] wgt_l_reg, wgt_l_next;
    logic [PW-1:0]    ptr_reg, ptr_next;

    logic [N-1:0]     sel;
    logic [PW-1:0]    sel_idx, owner_idx, owner_nxt, start_idx;
    logic [WIDTH-1:0] wgt_sel;
    logic             own_req, acc, rel;

    function automatic logic [PW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++)
            if (oh[i]) idx = idx | PW'(i);
        return idx;
    endfunction

    assign owner_idx = onehot_to_idx(gnt_reg);
    assign owner_nxt = (owner_idx == PW'(N - 1)) ? '0 : owner_idx + PW'(1);
    // While busy the search always starts just past the owner, so the owner is eligible last.
    assign start_idx = (state_reg == BUSY) ? owner_nxt : ptr_reg;

    generate
        if (IMPLEMENTATION == 0) begin : g_masked
            logic [N-1:0] hi_mask, req_hi, pick_hi, pick_all;
            for (genvar gi = 0; gi < N; gi++) begin : g_mask
                assign hi_mask[gi] = (PW'(gi) >= start_idx);
            end
            assign req_hi   = req & hi_mask;
            assign pick_hi  = req_hi & (~req_hi + N'(1));
            assign pick_all = req & (~req + N'(1));
            assign sel      = (|req_hi) ? pick_hi : pick_all;
        end else if (IMPLEMENTATION == 1) begin : g_rotate
            logic [2*N-1:0] rot_dbl, unrot_dbl;
            logic [N-1:0]   req_rot, pick_rot;
            assign rot_dbl   = {req, req} >> start_idx;
            assign req_rot   = rot_dbl[N-1:0];
            assign pick_rot  = req_rot & (~req_rot + N'(1));
            assign unrot_dbl = {pick_rot, pick_rot} << start_idx;
            assign sel       = unrot_dbl[2*N-1:N];
        end else begin : g_bad
            $fatal(1, "arbiter_weighted_rr: IMPLEMENTATION must be 0 or 1");
        end
    endgenerate

    assign sel_idx = onehot_to_idx(sel);
    assign wgt_sel = wgt[sel_idx*WIDTH +: WIDTH];

    assign own_req = |(req & gnt_reg);
    assign acc     = ack & own_req;
    assign pls     = acc & (cnt_reg == wgt_l_reg);
    assign rel     = pls | ~own_req;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        cnt_next   = cnt_reg;
        wgt_l_next = wgt_l_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    gnt_next   = sel;
                    wgt_l_next = wgt_sel;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    ptr_next = owner_nxt;
                    cnt_next = '0;
                    if (|req) begin
                        gnt_next   = sel;
                        wgt_l_next = wgt_sel;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (acc) begin
                    cnt_next = cnt_reg + WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            cnt_reg   <= '0;
            wgt_l_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            cnt_reg   <= cnt_next;
            wgt_l_reg <= wgt_l_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign gnt = gnt_reg;
    assign cnt = cnt_reg;

endmodule

// File: tb/tb_arbiter_weighted_rr.sv
// Scoreboard bench for arbiter_weighted_rr: both selector implementations run side by side
// on identical stimulus and are checked against the same hand-derived per-cycle expectations.
module tb_arbiter_weighted_rr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] wgt = '0;
    logic        ack = 1'b0;

    logic [3:0]  gnt0, gnt1;
    logic [7:0]  cnt0, cnt1;
    logic        pls0, pls1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] cnt;
        logic       pls;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    arbiter_weighted_rr #(.N(4), .WIDTH(8), .IMPLEMENTATION(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .wgt(wgt), .ack(ack),
        .gnt(gnt0), .cnt(cnt0), .pls(pls0)
    );

    arbiter_weighted_rr #(.N(4), .WIDTH(8), .IMPLEMENTATION(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .wgt(wgt), .ack(ack),
        .gnt(gnt1), .cnt(cnt1), .pls(pls1)
    );

    task automatic cmp(input string tag, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, expv);
        end
    endtask

    // Monitor: every cycle the outputs are presented; pop and compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("[%0t] %s: gnt %b/%b cnt %0d/%0d pls %b/%b", $time, e.name,
                     gnt0, gnt1, cnt0, cnt1, pls0, pls1);
            cmp({e.name, " impl0 gnt"}, {4'b0, gnt0}, {4'b0, e.gnt});
            cmp({e.name, " impl0 cnt"}, cnt0, e.cnt);
            cmp({e.name, " impl0 pls"}, {7'b0, pls0}, {7'b0, e.pls});
            cmp({e.name, " impl1 gnt"}, {4'b0, gnt1}, {4'b0, e.gnt});
            cmp({e.name, " impl1 cnt"}, cnt1, e.cnt);
            cmp({e.name, " impl1 pls"}, {7'b0, pls1}, {7'b0, e.pls});
        end
    end

    // Drive one cycle of inputs just after the edge and queue what the outputs must show.
    task automatic step(input logic r, input logic [3:0] rq, input logic a,
                        input logic [3:0] eg, input logic [7:0] ec, input logic ep,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        req = rq;
        ack = a;
        e.gnt  = eg;
        e.cnt  = ec;
        e.pls  = ep;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset held with requests and acks present
        step(1, 4'b1111, 1, 4'b0000, 0, 0, "rst_hold0");
        step(1, 4'b1111, 1, 4'b0000, 0, 0, "rst_hold1");
        step(0, 4'b0000, 0, 4'b0000, 0, 0, "rst_rel");

        // single requester, wgt[1]=2: three transfers then re-grant to itself
        wgt = {8'd0, 8'd0, 8'd2, 8'd0};
        step(0, 4'b0010, 1, 4'b0000, 0, 0, "s2_idle");
        step(0, 4'b0010, 1, 4'b0010, 0, 0, "s2_c0");
        step(0, 4'b0010, 1, 4'b0010, 1, 0, "s2_c1");
        step(0, 4'b0010, 1, 4'b0010, 2, 1, "s2_last");
        step(0, 4'b0000, 0, 4'b0010, 0, 0, "s2_regrant");
        step(0, 4'b0000, 0, 4'b0000, 0, 0, "s2_idle_end");

        // all request, all weight 0: rotation every cycle
        wgt = '0;
        step(1, 4'b0000, 0, 4'b0000, 0, 0, "s3_rst");
        step(0, 4'b1111, 1, 4'b0000, 0, 0, "s3_idle");
        step(0, 4'b1111, 1, 4'b0001, 0, 1, "s3_g0");
        step(0, 4'b1111, 1, 4'b0010, 0, 1, "s3_g1");
        step(0, 4'b1111, 1, 4'b0100, 0, 1, "s3_g2");
        step(0, 4'b1111, 1, 4'b1000, 0, 1, "s3_g3");
        step(0, 4'b1111, 1, 4'b0001, 0, 1, "s3_wrap");
        step(0, 4'b0000, 0, 4'b0010, 0, 0, "s3_drop");
        step(0, 4'b0000, 0, 4'b0000, 0, 0, "s3_idle_end");

        // owner 0 drops request after one transfer: handover without pls
        wgt = {8'd0, 8'd0, 8'd0, 8'd5};
        step(1, 4'b0000, 0, 4'b0000, 0, 0, "s4_rst");
        step(0, 4'b0101, 0, 4'b0000, 0, 0, "s4_idle");
        step(0, 4'b0101, 1, 4'b0001, 0, 0, "s4_ack");
        step(0, 4'b0100, 0, 4'b0001, 1, 0, "s4_drop");
        step(0, 4'b0100, 0, 4'b0100, 0, 0, "s4_handover");
        step(0, 4'b0000, 0, 4'b0100, 0, 0, "s4_release");
        step(0, 4'b0000, 0, 4'b0000, 0, 0, "s4_idle_end");

        // weight sampled at grant start only; acks while idle ignored
        wgt = {8'd0, 8'd0, 8'd1, 8'd0};
        step(0, 4'b0010, 0, 4'b0000, 0, 0, "s5_idle");
        step(0, 4'b0010, 1, 4'b0010, 0, 0, "s5_a0");
        wgt = {8'd0, 8'd0, 8'd7, 8'd0};
        step(0, 4'b0010, 1, 4'b0010, 1, 1, "s5_a1_last");
        for (int i = 0; i < 8; i++)
            step(0, 4'b0010, 1, 4'b0010, 8'(i), (i == 7), $sformatf("s5_long%0d", i));
        step(0, 4'b0000, 1, 4'b0010, 0, 0, "s5_drop_ack");
        step(0, 4'b0000, 1, 4'b0000, 0, 0, "s5_idle_ack0");
        step(0, 4'b0000, 1, 4'b0000, 0, 0, "s5_idle_ack1");

        // reset mid-grant, then restart from pointer 0
        wgt = {8'd0, 8'd5, 8'd0, 8'd0};
        step(0, 4'b0100, 0, 4'b0000, 0, 0, "s6_idle");
        step(0, 4'b0100, 1, 4'b0100, 0, 0, "s6_a0");
        step(0, 4'b0100, 1, 4'b0100, 1, 0, "s6_a1");
        step(0, 4'b0100, 1, 4'b0100, 2, 0, "s6_a2");
        step(0, 4'b0100, 0, 4'b0100, 3, 0, "s6_hold");
        step(1, 4'b1001, 0, 4'b0000, 0, 0, "s6_rst");
        step(0, 4'b1001, 0, 4'b0000, 0, 0, "s6_rst_rel");
        step(0, 4'b1001, 0, 4'b0001, 0, 0, "s6_restart");
        step(0, 4'b0000, 0, 4'b0001, 0, 0, "s6_release");

        // maximum weight: 256 transfers, counter must not overflow
        wgt = {8'd255, 8'd0, 8'd0, 8'd0};
        step(0, 4'b1000, 0, 4'b0000, 0, 0, "s7_idle");
        for (int i = 0; i < 256; i++)
            step(0, 4'b1000, 1, 4'b1000, 8'(i), (i == 255), $sformatf("s7_c%0d", i));
        step(0, 4'b0000, 0, 4'b1000, 0, 0, "s7_drop");
        step(0, 4'b0000, 0, 4'b0000, 0, 0, "s7_idle_end");

        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
